// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit ripple-carry full-adder slice.
module addsub_chunk #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic cy;

  always_comb begin
    s  = '0;
    cy = cin;
    for (int unsigned i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor, CHUNK bits per cycle through one shared slice.
// Optional saturation on signed overflow with ADDSUB_SAT_EN.
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t state, state_next;

  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry_r, cout_r, ovf_r, zero_r;
  logic [CNT_W-1:0] cnt, idx;
  logic [31:0]      base;
  logic             accept, chunk_step, finish;

  logic [CHUNK-1:0] ca, cb, cs;
  logic             cc;

  logic [WIDTH-1:0] fin_sum;
  logic             fin_ovf;

`ifdef ADDSUB_SAT_EN
  logic sat_r;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // BUSY runs NCHUNK chunk cycles and then one finalise cycle (cnt == LAST) that
  // derives flags and saturation from the fully registered sum.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    chunk_step = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          chunk_step = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    idx  = (cnt < LAST) ? cnt : '0;
    base = 32'(idx) * CHUNK;
    ca   = a_r[base +: CHUNK];
    cb   = b_r[base +: CHUNK];
  end

  addsub_chunk #(.W(CHUNK)) u_chunk (
    .a    (ca),
    .b    (cb),
    .cin  (carry_r),
    .s    (cs),
    .cout (cc)
  );

  always_comb begin
    fin_ovf = signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], sum_r[WIDTH-1]);
    fin_sum = sum_r;
`ifdef ADDSUB_SAT_EN
    if (sat_r && fin_ovf) fin_sum = {a_r[WIDTH-1], {(WIDTH-1){~a_r[WIDTH-1]}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
`ifdef ADDSUB_SAT_EN
      sat_r   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_r     <= a;
        b_r     <= (op == OP_SUB) ? ~b : b;
        carry_r <= (op == OP_SUB) ? ~cin : cin;
        cnt     <= '0;
`ifdef ADDSUB_SAT_EN
        sat_r   <= sat;
`endif
      end
      if (chunk_step) begin
        sum_r[base +: CHUNK] <= cs;
        carry_r              <= cc;
        cnt                  <= cnt + 1'b1;
      end
      if (finish) begin
        sum_r  <= fin_sum;
        cout_r <= carry_r;
        ovf_r  <= fin_ovf;
        zero_r <= (fin_sum == '0);
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;
  assign zero = zero_r;

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub (WIDTH=16, CHUNK=4); honours ADDSUB_SAT_EN.
module tb_seq_addsub;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0, op = 1'b0, sat_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout, ovf, zero;

  int   n_cmp = 0, n_bad = 0;
  int   n_acc = 0, n_res = 0, n_drop = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
`ifdef ADDSUB_SAT_EN
    .sat       (sat_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Reference: plain integer arithmetic on the operands as written.
  function automatic res_t model(input logic o, input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input logic s);
    res_t m;
    int   sx, sy, r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o) begin
      r      = sx - sy - int'(c);
      m.cout = (int'(x) >= int'(y) + int'(c));
    end else begin
      r      = sx + sy + int'(c);
      m.cout = (int'(x) + int'(y) + int'(c)) > 65535;
    end
    m.ovf = (r > 32767) || (r < -32768);
    m.sum = r[15:0];
    if (s && m.ovf) m.sum = (r > 0) ? 16'h7FFF : 16'h8000;
    m.zero = (m.sum == 16'h0000);
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Compare process: every DONE cycle is checked against the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      n_drop += exp_q.size();
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op, a, b, cin, sat_in));
        n_acc++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_result: actual sum %0h required no result", sum);
        end else begin
          chk("sum",  32'(sum),  32'(exp_q[0].sum));
          chk("cout", 32'(cout), 32'(exp_q[0].cout));
          chk("ovf",  32'(ovf),  32'(exp_q[0].ovf));
          chk("zero", 32'(zero), 32'(exp_q[0].zero));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_res++;
          end
        end
      end
    end
  end

  task automatic send(input logic o, input logic [15:0] x, input logic [15:0] y,
                      input logic c, input logic s);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    op = o; a = x; b = y; cin = c; sat_in = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); op = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic lit(input string name, input logic [15:0] s, input logic co,
                     input logic ov, input logic z);
    chk({name, "_sum"},  32'(sum),  32'(s));
    chk({name, "_cout"}, 32'(cout), 32'(co));
    chk({name, "_ovf"},  32'(ovf),  32'(ov));
    chk({name, "_zero"}, 32'(zero), 32'(z));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   sent;
    int   cyc;
    res_t pin;
    logic [15:0] snap;

    pin = model(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0); chk("pin_add", 32'(pin.sum), 32'h2233);
    pin = model(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b0); chk("pin_sub_cout", 32'(pin.cout), 32'd0);
    pin = model(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1); chk("pin_sat", 32'(pin.sum), 32'h8000);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    lit("rst", 16'h0000, 1'b0, 1'b0, 1'b0);

    send(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0); wait_valid(lat);
    chk("latency", 32'(lat), 32'd5);
    lit("add1", 16'h2233, 1'b0, 1'b0, 1'b0);

    send(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b0); wait_valid(lat);
    lit("sub_borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0);

    send(1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0); wait_valid(lat);
    lit("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);

    send(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_valid(lat);
    lit("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);

    send(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0); wait_valid(lat);
    lit("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);

    send(1'b1, 16'h0005, 16'h0003, 1'b1, 1'b0); wait_valid(lat);
    lit("sub_cin", 16'h0001, 1'b1, 1'b0, 1'b0);

`ifdef ADDSUB_SAT_EN
    send(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b1); wait_valid(lat);
    lit("sat_pos", 16'h7FFF, 1'b0, 1'b1, 1'b0);
    send(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1); wait_valid(lat);
    lit("sat_neg", 16'h8000, 1'b1, 1'b1, 1'b0);
`endif

    // Backpressure: hold the result for three cycles while in_valid pulses.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0); wait_valid(lat);
    snap = sum;
    chk("bp_first", 32'(snap), 32'h0100);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'h5555; b = 16'h1111;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      lit("bp_hold", 16'h0100, 1'b0, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready),  32'd1);

    // Abort mid-BUSY, then make sure no carry survives into the next op.
    send(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    send(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0); wait_valid(lat);
    lit("after_abort", 16'h0002, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Random traffic with toggling out_ready and ignored in_valid pulses.
    sent = 0;
    cyc  = 0;
    while ((sent < 40 || exp_q.size() != 0 || out_valid) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      in_valid  = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 40 && $urandom_range(0, 3) != 0) begin
        op = 1'($urandom); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef ADDSUB_SAT_EN
        sat_in = 1'($urandom);
`endif
        if (in_ready) sent++;
        in_valid = 1'b1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 3000) chk("random_timeout", 32'(cyc), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("no_lost_ops", 32'(n_res + n_drop), 32'(n_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
